run_controller: RTL and testbench
=================================

# run_controller

Sequencing controller for the player datapath: owns the run/death lifecycle, generates the movement tick, and decides when gravity flips. It drives `grav_dir` and the freeze signal into the player-height block and consumes that block's `height` plus the per-column `lines` ground map. A flip request is honoured only when the player is resting on a line, with a short press buffer. The block also keeps a per-run survival score.

## Interface
- `TICK_DIV`, 100000: clk cycles per movement tick (≥2).
- `BUF_TICKS`, 8: movement ticks a buffered flip press stays valid (≥1).
- `FLOOR_MIN`, 0: `height` ≤ this is death (fell off bottom).
- `CEIL_MAX`, 420: `height` ≥ this is death (fell off top).
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_flip` in 1: flip button, already synchronised/debounced level.
- `btn_start` in 1: start/restart button, already synchronised/debounced level.
- `hit` in 1: obstacle collision, level, valid any cycle.
- `height` in 9: current player bottom-left height.
- `lines` in 3: ground present at heights 120/240/360 under the player.
- `grav_dir` out 1: 0 down, 1 up.
- `freeze` out 1: 1 holds player height (drives player block's dead/hold input).
- `move_tick` out 1: one-cycle pulse per movement step.
- `dead` out 1: high in DEAD state.
- `score` out 16: movement ticks survived this run, saturating.
- `state` out 2: 00 IDLE, 01 RUN, 10 DEAD.

## Operation
- Reset (async, `rst_n`=0): state IDLE, `grav_dir`=0, `freeze`=1, `dead`=0, `move_tick`=0, `score`=0, tick counter 0, flip pending 0, both button edge registers 0.
- Edge detect: `start_edge` = `btn_start` & ~previous; `flip_edge` likewise. Previous-value registers update every cycle in all states.
- Grounded (combinational): `grav_dir`=0 & ((`height`=120 & `lines[0]`) | (`height`=240 & `lines[1]`)); `grav_dir`=1 & ((`height`=180 & `lines[1]`) | (`height`=300 & `lines[2]`)).
- Death condition: `hit` | `height` ≤ FLOOR_MIN | `height` ≥ CEIL_MAX.
- IDLE: `freeze`=1, counter held 0. `start_edge` → RUN; on that transition `score`←0, `grav_dir`←0, pending←0.
- RUN: `freeze`=0. Counter counts 0..TICK_DIV-1 and wraps; `move_tick`=1 exactly when counter = TICK_DIV-1. `score` +1 per `move_tick`, saturating at 65535.
- Flip buffer: `flip_edge` in RUN sets pending and loads window counter with BUF_TICKS (a new edge while pending reloads it). Each `move_tick` while pending and not applied decrements window; reaching 0 clears pending (press dropped).
- Flip apply: pending (or `flip_edge` this cycle) & grounded → `grav_dir` toggles next edge, pending cleared. At most one toggle per cycle.
- Death condition true in RUN → DEAD next edge; death has priority over flip apply and `move_tick` scoring in the same cycle (`grav_dir` and `score` unchanged).
- DEAD: `freeze`=1, `dead`=1, counter held 0, pending cleared, `score` and `grav_dir` held. `start_edge` → IDLE (not directly to RUN).
- `btn_flip` ignored outside RUN; a held `btn_start` does not retrigger.

## Timing
- All outputs registered except `state` decode; `freeze`/`dead` change the edge after the state change is registered (same edge as state).
- Start latency: `btn_start` rising sampled at edge N → state RUN, `freeze`=0 after edge N. First `move_tick` TICK_DIV cycles later.
- Flip latency: edge seen at N while grounded → `grav_dir` toggled after edge N.
- Death latency: condition at edge N → DEAD/`freeze`=1 after edge N; player block sees freeze before its next step.
- Reset mid-run asynchronously forces IDLE values immediately.

## Test plan
- Reset: `rst_n`=0 mid-RUN with `grav_dir`=1, `score`=37 → immediately IDLE, `freeze`=1, `grav_dir`=0, `score`=0.
- Start and tick (TICK_DIV=4): `btn_start` pulse → RUN; `move_tick` every 4th cycle; after 10 ticks `score`=10; holding `btn_start` high does not restart.
- Grounded flip: RUN, `grav_dir`=0, `height`=240, `lines`=010, `btn_flip` rise → `grav_dir`=1 next cycle.
- Buffered flip (BUF_TICKS=2): press at `height`=250 airborne, `height` reaches 240 with `lines[1]`=1 one tick later → toggle; repeat with landing after 3 ticks → no toggle.
- Death priority: `hit`=1 same cycle as grounded `flip_edge` and `move_tick` → DEAD, `grav_dir`, `score` unchanged; `height`=420 alone → DEAD.
- Restart: DEAD, `btn_start` rise → IDLE; second rise → RUN with `score`=0, `grav_dir`=0.

Source files
------------

// File: rtl/run_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_controller_if : player-datapath control bundle for run_controller |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface run_controller_if;
  logic       btn_flip;
  logic       btn_start;
  logic       hit;
  logic [8:0] height;
  logic [2:0] lines;
  logic       grav_dir;
  logic       freeze;
  logic       move_tick;
  logic       dead;
  logic [15:0] score;
  logic [1:0] state;

  modport master (
    output btn_flip, btn_start, hit, height, lines,
    input  grav_dir, freeze, move_tick, dead, score, state
  );

  modport slave (
    input  btn_flip, btn_start, hit, height, lines,
    output grav_dir, freeze, move_tick, dead, score, state
  );
endinterface
`default_nettype wire

// File: rtl/run_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_controller : run/death lifecycle, movement tick and gravity flip  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module run_controller #(
  parameter int TICK_DIV  = 100000,
  parameter int BUF_TICKS = 8,
  parameter int FLOOR_MIN = 0,
  parameter int CEIL_MAX  = 420
) (
  input  logic             clk,
  input  logic             rst_n,
  run_controller_if.slave  bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WIN_W = $clog2(BUF_TICKS + 1);

  localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [WIN_W-1:0] c_win_load  = WIN_W'(BUF_TICKS);
  localparam logic [WIN_W-1:0] c_win_one   = WIN_W'(1);
  localparam logic [8:0]       c_floor     = 9'(FLOOR_MIN);
  localparam logic [8:0]       c_ceil      = 9'(CEIL_MAX);
  localparam logic [15:0]      c_score_max = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DEAD = 2'b10
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIN_W-1:0] r_win;
  logic             r_pend;
  logic             r_grav;
  logic [15:0]      r_score;
  logic             r_freeze;
  logic             r_dead;
  logic             r_tick;
  logic             r_flip_prev;
  logic             r_start_prev;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIN_W-1:0] w_win_nxt;
  logic             w_pend_nxt;
  logic             w_grav_nxt;
  logic [15:0]      w_score_nxt;
  logic             w_start_edge;
  logic             w_flip_edge;
  logic             w_grounded;
  logic             w_death;
  logic             w_tick;

  always_comb begin
    w_start_edge = bus.btn_start & ~r_start_prev;
    w_flip_edge  = bus.btn_flip  & ~r_flip_prev;
    // Resting positions depend on which way gravity pulls.
    if (r_grav) begin
      w_grounded = ((bus.height == 9'd180) & bus.lines[1]) |
                   ((bus.height == 9'd300) & bus.lines[2]);
    end else begin
      w_grounded = ((bus.height == 9'd120) & bus.lines[0]) |
                   ((bus.height == 9'd240) & bus.lines[1]);
    end
    w_death = bus.hit | (bus.height <= c_floor) | (bus.height >= c_ceil);
    w_tick  = (r_state == S_RUN) && (r_cnt == c_tick_last);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_win_nxt   = r_win;
    w_pend_nxt  = r_pend;
    w_grav_nxt  = r_grav;
    w_score_nxt = r_score;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_start_edge) begin
          w_state_nxt = S_RUN;
          w_score_nxt = '0;
          w_grav_nxt  = 1'b0;
          w_pend_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        if (w_death) begin
          w_state_nxt = S_DEAD;
          w_cnt_nxt   = '0;
          w_pend_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = w_tick ? '0 : (r_cnt + c_cnt_one);
          if (w_tick && (r_score != c_score_max)) begin
            w_score_nxt = r_score + 16'd1;
          end
          // Applying a flip beats reloading or ageing the press buffer.
          if ((r_pend | w_flip_edge) & w_grounded) begin
            w_grav_nxt = ~r_grav;
            w_pend_nxt = 1'b0;
          end else if (w_flip_edge) begin
            w_pend_nxt = 1'b1;
            w_win_nxt  = c_win_load;
          end else if (r_pend && w_tick) begin
            w_win_nxt = r_win - c_win_one;
            if (r_win == c_win_one) begin
              w_pend_nxt = 1'b0;
            end
          end
        end
      end
      S_DEAD: begin
        w_cnt_nxt  = '0;
        w_pend_nxt = 1'b0;
        if (w_start_edge) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_win        <= '0;
      r_pend       <= 1'b0;
      r_grav       <= 1'b0;
      r_score      <= '0;
      r_freeze     <= 1'b1;
      r_dead       <= 1'b0;
      r_tick       <= 1'b0;
      r_flip_prev  <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_win        <= w_win_nxt;
      r_pend       <= w_pend_nxt;
      r_grav       <= w_grav_nxt;
      r_score      <= w_score_nxt;
      r_freeze     <= (w_state_nxt != S_RUN);
      r_dead       <= (w_state_nxt == S_DEAD);
      r_tick       <= (w_state_nxt == S_RUN) && (w_cnt_nxt == c_tick_last);
      r_flip_prev  <= bus.btn_flip;
      r_start_prev <= bus.btn_start;
    end
  end

  assign bus.grav_dir  = r_grav;
  assign bus.freeze    = r_freeze;
  assign bus.dead      = r_dead;
  assign bus.move_tick = r_tick;
  assign bus.score     = r_score;
  assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_run_controller : randomized bench with behavioural reference model |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_run_controller;

  localparam int TICK_DIV  = 4;
  localparam int BUF_TICKS = 2;
  localparam int FLOOR_MIN = 0;
  localparam int CEIL_MAX  = 420;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  run_controller_if bus ();

  run_controller #(
    .TICK_DIV (TICK_DIV),
    .BUF_TICKS(BUF_TICKS),
    .FLOOR_MIN(FLOOR_MIN),
    .CEIL_MAX (CEIL_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase = cycles spent in the current run, press kept as ticks-left.
  int m_state = 0;
  int m_age   = 0;
  int m_score = 0;
  int m_left  = 0;
  bit m_grav  = 1'b0;
  bit m_pend  = 1'b0;
  bit m_pf    = 1'b0;
  bit m_ps    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int  ns, nage, nscore, nleft;
    bit  ngrav, npend, fe, se, gnd, die, tick;
    if (!rst_n) begin
      m_state <= 0; m_age <= 0; m_score <= 0; m_left <= 0;
      m_grav  <= 1'b0; m_pend <= 1'b0; m_pf <= 1'b0; m_ps <= 1'b0;
    end else begin
      ns = m_state; nage = m_age; nscore = m_score; nleft = m_left;
      ngrav = m_grav; npend = m_pend;
      fe  = bus.btn_flip & ~m_pf;
      se  = bus.btn_start & ~m_ps;
      gnd = m_grav ? ((bus.height == 180 && bus.lines[1]) || (bus.height == 300 && bus.lines[2]))
                   : ((bus.height == 120 && bus.lines[0]) || (bus.height == 240 && bus.lines[1]));
      die = bus.hit || (int'(bus.height) <= FLOOR_MIN) || (int'(bus.height) >= CEIL_MAX);
      tick = (m_state == 1) && ((m_age % TICK_DIV) == TICK_DIV - 1);
      if (m_state == 0) begin
        if (se) begin ns = 1; nage = 0; nscore = 0; ngrav = 1'b0; npend = 1'b0; end
      end else if (m_state == 1) begin
        if (die) begin
          ns = 2; npend = 1'b0;
        end else begin
          nage = m_age + 1;
          if (tick && m_score < 65535) nscore = m_score + 1;
          if ((m_pend || fe) && gnd) begin
            ngrav = ~m_grav; npend = 1'b0;
          end else if (fe) begin
            npend = 1'b1; nleft = BUF_TICKS;
          end else if (m_pend && tick) begin
            nleft = m_left - 1;
            if (nleft == 0) npend = 1'b0;
          end
        end
      end else begin
        npend = 1'b0;
        if (se) ns = 0;
      end
      m_state <= ns; m_age <= nage; m_score <= nscore; m_left <= nleft;
      m_grav  <= ngrav; m_pend <= npend;
      m_pf    <= bus.btn_flip; m_ps <= bus.btn_start;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_state",     32'(bus.state),     32'(m_state));
      chk("cmp_freeze",    32'(bus.freeze),    32'(m_state != 1));
      chk("cmp_dead",      32'(bus.dead),      32'(m_state == 2));
      chk("cmp_move_tick", 32'(bus.move_tick),
          32'((m_state == 1) && ((m_age % TICK_DIV) == TICK_DIV - 1)));
      chk("cmp_score",     32'(bus.score),     32'(m_score));
      chk("cmp_grav_dir",  32'(bus.grav_dir),  32'(m_grav));
    end
  end

  task automatic nc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_ticks(input int n, input string name);
    int seen = 0;
    for (int i = 0; i < 64 * n && seen < n; i++) begin
      nc(1);
      if (bus.move_tick === 1'b1) seen++;
    end
    if (seen < n) begin
      tests++; fails++;
      $display("FAIL %s: timeout, saw %0d move_tick need %0d", name, seen, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $fatal(1);
  end

  logic [8:0] hts [9] = '{9'd120, 9'd180, 9'd240, 9'd300, 9'd250, 9'd200, 9'd1, 9'd419, 9'd360};

  initial begin
    int s_score;
    bit s_grav;
    int r;
    bus.btn_flip = 1'b0; bus.btn_start = 1'b0; bus.hit = 1'b0;
    bus.height = 9'd200; bus.lines = 3'b000;
    nc(3);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_freeze", 32'(bus.freeze), 32'd1);
    chk("rst_grav", 32'(bus.grav_dir), 32'd0);
    chk("rst_score", 32'(bus.score), 32'd0);
    chk("rst_dead", 32'(bus.dead), 32'd0);
    chk("rst_tick", 32'(bus.move_tick), 32'd0);
    rst_n = 1'b1; chk_en = 1'b1;
    nc(1);

    // Start, then hold start high through ten ticks.
    bus.btn_start = 1'b1; nc(1);
    chk("start_state", 32'(bus.state), 32'd1);
    chk("start_freeze", 32'(bus.freeze), 32'd0);
    nc(40);
    chk("ten_ticks_score", 32'(bus.score), 32'd10);
    chk("model_score10", 32'(m_score), 32'd10);
    chk("held_start_state", 32'(bus.state), 32'd1);
    bus.btn_start = 1'b0;

    // Grounded flip.
    bus.height = 9'd240; bus.lines = 3'b010; bus.btn_flip = 1'b1; nc(1);
    chk("grounded_flip", 32'(bus.grav_dir), 32'd1);
    chk("model_grav1", 32'(m_grav), 32'd1);
    bus.btn_flip = 1'b0; bus.height = 9'd250; bus.lines = 3'b000; nc(2);

    // Buffered press lands within the window.
    bus.btn_flip = 1'b1; nc(1);
    bus.btn_flip = 1'b0;
    wait_ticks(1, "buf_hit_wait");
    bus.height = 9'd180; bus.lines = 3'b010; nc(1);
    chk("buf_hit_toggle", 32'(bus.grav_dir), 32'd0);
    bus.height = 9'd250; bus.lines = 3'b000; nc(2);

    // Buffered press expires before landing.
    bus.btn_flip = 1'b1; nc(1);
    bus.btn_flip = 1'b0;
    wait_ticks(3, "buf_miss_wait");
    bus.height = 9'd240; bus.lines = 3'b010; nc(2);
    chk("buf_miss_no_toggle", 32'(bus.grav_dir), 32'd0);
    bus.btn_flip = 1'b1; nc(1);
    chk("second_flip", 32'(bus.grav_dir), 32'd1);
    bus.btn_flip = 1'b0; bus.height = 9'd250; bus.lines = 3'b000;

    // Hit in the same cycle as a tick and a grounded flip edge.
    wait_ticks(1, "death_wait");
    s_score = m_score; s_grav = m_grav;
    bus.height = 9'd180; bus.lines = 3'b010; bus.btn_flip = 1'b1; bus.hit = 1'b1; nc(1);
    chk("death_state", 32'(bus.state), 32'd2);
    chk("death_dead", 32'(bus.dead), 32'd1);
    chk("death_freeze", 32'(bus.freeze), 32'd1);
    chk("death_grav_held", 32'(bus.grav_dir), 32'(s_grav));
    chk("death_score_held", 32'(bus.score), 32'(s_score));
    bus.hit = 1'b0; bus.btn_flip = 1'b0; bus.height = 9'd250; bus.lines = 3'b000; nc(2);

    // Restart goes through IDLE.
    bus.btn_start = 1'b1; nc(1);
    chk("restart_idle", 32'(bus.state), 32'd0);
    bus.btn_start = 1'b0; nc(1);
    bus.btn_start = 1'b1; nc(1);
    chk("restart_run", 32'(bus.state), 32'd1);
    chk("restart_score", 32'(bus.score), 32'd0);
    chk("restart_grav", 32'(bus.grav_dir), 32'd0);
    bus.btn_start = 1'b0; nc(5);

    bus.height = 9'd420; nc(1);
    chk("ceil_death", 32'(bus.state), 32'd2);
    bus.height = 9'd250; nc(1);

    // Asynchronous reset in the middle of a run.
    bus.btn_start = 1'b1; nc(1);
    bus.btn_start = 1'b0; nc(1);
    bus.btn_start = 1'b1; nc(1);
    bus.btn_start = 1'b0;
    bus.height = 9'd240; bus.lines = 3'b010; bus.btn_flip = 1'b1; nc(1);
    bus.btn_flip = 1'b0; bus.height = 9'd250; bus.lines = 3'b000;
    for (int i = 0; i < 400 && m_score != 37; i++) nc(1);
    chk("pre_rst_score", 32'(bus.score), 32'd37);
    chk("pre_rst_grav", 32'(bus.grav_dir), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(bus.state), 32'd0);
    chk("async_rst_freeze", 32'(bus.freeze), 32'd1);
    chk("async_rst_grav", 32'(bus.grav_dir), 32'd0);
    chk("async_rst_score", 32'(bus.score), 32'd0);
    nc(2);
    rst_n = 1'b1;

    // Randomized traffic checked every cycle by the compare process.
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 3) == 0) bus.btn_flip = ~bus.btn_flip;
      if ($urandom_range(0, 29) == 0) bus.btn_start = ~bus.btn_start;
      bus.hit = ($urandom_range(0, 199) == 0);
      bus.lines = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 99);
      if (r < 1)      bus.height = 9'd0;
      else if (r < 2) bus.height = 9'd420;
      else if (r < 3) bus.height = 9'($urandom_range(421, 511));
      else            bus.height = hts[$urandom_range(0, 8)];
      if (it == 1500) begin
        rst_n = 1'b0; nc(1); rst_n = 1'b1;
      end
      nc(1);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
